// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM state type and word-count/width helpers for serial_loader
package loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    function automatic int words(input int n, input int w);
        return (n + w - 1) / w;
    endfunction

    function automatic int addr_w(input int n, input int w);
        return words(n, w) > 1 ? $clog2(words(n, w)) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/word_packer.sv
// word_packer: packs a serial bit stream LSB-first into words and emits a registered write port
module word_packer
    import loader_pkg::*;
#(
    parameter int N      = 784,
    parameter int WORD_W = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clr,
    input  logic                          cap,
    input  logic                          bit_in,
    output logic                          near,
    output logic                          we,
    output logic [addr_w(N, WORD_W)-1:0]  addr,
    output logic [WORD_W-1:0]             wdata
);

    localparam int AW = addr_w(N, WORD_W);
    localparam int CW = cnt_w(N);
    localparam int PW = WORD_W > 1 ? $clog2(WORD_W) : 1;

    logic [CW-1:0]     cnt;
    logic [PW-1:0]     pos;
    logic [AW-1:0]     widx;
    logic [WORD_W-1:0] sh;
    logic [WORD_W-1:0] sh_nxt;
    logic              take;
    logic              full;

    assign take   = cap && (cnt < CW'(N));
    assign sh_nxt = sh | (WORD_W'(bit_in) << pos);
    assign full   = (pos == PW'(WORD_W - 1)) || (cnt == CW'(N - 1));
    assign near   = cnt >= CW'(N - 1);

    // bit counter and shift register; flush the word on its last bit or the stream's last bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            pos   <= '0;
            widx  <= '0;
            sh    <= '0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            we <= 1'b0;
            if (clr) begin
                cnt  <= '0;
                pos  <= '0;
                widx <= '0;
                sh   <= '0;
            end else if (take) begin
                cnt <= cnt + 1'b1;
                if (full) begin
                    pos   <= '0;
                    widx  <= widx + 1'b1;
                    sh    <= '0;
                    we    <= 1'b1;
                    addr  <= widx;
                    wdata <= sh_nxt;
                end else begin
                    pos <= pos + 1'b1;
                    sh  <= sh_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/serial_loader.sv
// serial_loader: frames one pixel/weight load per start and deserializes both streams into buffer words
module serial_loader
    import loader_pkg::*;
#(
    parameter int NUM_PIX = 784,
    parameter int NUM_WGT = 7840,
    parameter int WORD_W  = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic                                sync_p,
    input  logic                                sync_w,
    input  logic                                sync_strobe,
    output logic                                pix_we,
    output logic [addr_w(NUM_PIX, WORD_W)-1:0]  pix_addr,
    output logic [WORD_W-1:0]                   pix_wdata,
    output logic                                wgt_we,
    output logic [addr_w(NUM_WGT, WORD_W)-1:0]  wgt_addr,
    output logic [WORD_W-1:0]                   wgt_wdata,
    output logic                                busy,
    output logic                                done
);

    state_t state;
    state_t nxt;
    logic   strobe_q;
    logic   strobe_edge;
    logic   clr;
    logic   cap;
    logic   pix_near;
    logic   wgt_near;

    assign strobe_edge = sync_strobe & ~strobe_q;
    assign clr         = (state == IDLE) && start;
    assign cap         = (state == LOAD) && strobe_edge;

    // state register and strobe history, both free-running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            strobe_q <= 1'b0;
        end else begin
            state    <= nxt;
            strobe_q <= sync_strobe;
        end
    end

    // leave LOAD on the edge that captures the last bit of the longer stream
    always_comb begin
        nxt  = state;
        busy = state == LOAD;
        done = state == DONE;
        if (state == IDLE && start)
            nxt = LOAD;
        else if (state == LOAD && strobe_edge && pix_near && wgt_near)
            nxt = DONE;
        else if (state == DONE)
            nxt = IDLE;
    end

    word_packer #(.N(NUM_PIX), .WORD_W(WORD_W)) u_pix (
        .clk(clk), .reset_n(reset_n), .clr(clr), .cap(cap), .bit_in(sync_p),
        .near(pix_near), .we(pix_we), .addr(pix_addr), .wdata(pix_wdata)
    );

    word_packer #(.N(NUM_WGT), .WORD_W(WORD_W)) u_wgt (
        .clk(clk), .reset_n(reset_n), .clr(clr), .cap(cap), .bit_in(sync_w),
        .near(wgt_near), .we(wgt_we), .addr(wgt_addr), .wdata(wgt_wdata)
    );

endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: scoreboard bench for two serial_loader configurations sharing one bit stream
module tb_serial_loader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic sync_p = 1'b0;
    logic sync_w = 1'b0;
    logic sync_strobe = 1'b0;

    logic       a_pix_we, a_wgt_we, a_busy, a_done;
    logic [1:0] a_pix_addr, a_wgt_addr;
    logic [7:0] a_pix_wdata, a_wgt_wdata;
    logic       b_pix_we, b_wgt_we, b_busy, b_done;
    logic [0:0] b_pix_addr;
    logic [1:0] b_wgt_addr;
    logic [7:0] b_pix_wdata, b_wgt_wdata;

    serial_loader #(.NUM_PIX(20), .NUM_WGT(20), .WORD_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .sync_p(sync_p), .sync_w(sync_w),
        .sync_strobe(sync_strobe), .pix_we(a_pix_we), .pix_addr(a_pix_addr), .pix_wdata(a_pix_wdata),
        .wgt_we(a_wgt_we), .wgt_addr(a_wgt_addr), .wgt_wdata(a_wgt_wdata), .busy(a_busy), .done(a_done)
    );

    serial_loader #(.NUM_PIX(8), .NUM_WGT(24), .WORD_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .sync_p(sync_p), .sync_w(sync_w),
        .sync_strobe(sync_strobe), .pix_we(b_pix_we), .pix_addr(b_pix_addr), .pix_wdata(b_pix_wdata),
        .wgt_we(b_wgt_we), .wgt_addr(b_wgt_addr), .wgt_wdata(b_wgt_wdata), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int np[2] = '{20, 8};
    int nw[2] = '{20, 24};
    bit armed[2];
    bit fin[2];
    int k[2];
    int pacc[2];
    int wacc[2];
    int pq[2][$];
    int wq[2][$];
    int done_exp[2];
    int done_seen[2];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic arm(input int d);
        armed[d] = 1'b1;
        k[d] = 0;
        pacc[d] = 0;
        wacc[d] = 0;
    endtask

    // expected words: bit k lands at k%8 of word k/8, words flush at bit 7 or the last bit
    task automatic model_bit(input bit p, input bit w);
        for (int d = 0; d < 2; d++) begin
            if (armed[d]) begin
                if (k[d] < np[d]) begin
                    pacc[d] |= int'(p) << (k[d] % 8);
                    if (k[d] % 8 == 7 || k[d] == np[d] - 1) begin
                        pq[d].push_back((k[d] / 8) * 256 + pacc[d]);
                        pacc[d] = 0;
                    end
                end
                if (k[d] < nw[d]) begin
                    wacc[d] |= int'(w) << (k[d] % 8);
                    if (k[d] % 8 == 7 || k[d] == nw[d] - 1) begin
                        wq[d].push_back((k[d] / 8) * 256 + wacc[d]);
                        wacc[d] = 0;
                    end
                end
                k[d]++;
                if (k[d] >= (np[d] > nw[d] ? np[d] : nw[d])) begin
                    armed[d] = 1'b0;
                    fin[d] = 1'b1;
                    done_exp[d]++;
                end
            end
        end
    endtask

    task automatic do_start(input bit a, input bit b);
        @(negedge clk);
        start_a = a;
        start_b = b;
        if (a && !armed[0]) arm(0);
        if (b && !armed[1]) arm(1);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic strobe(input bit p, input bit w, input int hold);
        @(negedge clk);
        sync_p = p;
        sync_w = w;
        sync_strobe = 1'b1;
        model_bit(p, w);
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        sync_strobe = 1'b0;
    endtask

    task automatic got_word(input string tag, input int d, input bit is_w, input int val);
        if (is_w) begin
            if (wq[d].size() == 0) check({tag, "_extra"}, 1, 0);
            else check(tag, val, wq[d].pop_front());
        end else begin
            if (pq[d].size() == 0) check({tag, "_extra"}, 1, 0);
            else check(tag, val, pq[d].pop_front());
        end
    endtask

    task automatic end_phase(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_a_pix_pending"}, pq[0].size(), 0);
        check({tag, "_a_wgt_pending"}, wq[0].size(), 0);
        check({tag, "_b_pix_pending"}, pq[1].size(), 0);
        check({tag, "_b_wgt_pending"}, wq[1].size(), 0);
        check({tag, "_a_done_cnt"}, done_seen[0], done_exp[0]);
        check({tag, "_b_done_cnt"}, done_seen[1], done_exp[1]);
    endtask

    // write/done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (a_pix_we) got_word("a_pix", 0, 1'b0, int'(a_pix_addr) * 256 + int'(a_pix_wdata));
        if (a_wgt_we) got_word("a_wgt", 0, 1'b1, int'(a_wgt_addr) * 256 + int'(a_wgt_wdata));
        if (b_pix_we) got_word("b_pix", 1, 1'b0, int'(b_pix_addr) * 256 + int'(b_pix_wdata));
        if (b_wgt_we) got_word("b_wgt", 1, 1'b1, int'(b_wgt_addr) * 256 + int'(b_wgt_wdata));
        if (a_done) begin
            done_seen[0]++;
            check("a_done_timing", int'(fin[0]), 1);
            check("a_done_with_we", int'(a_pix_we && a_wgt_we), 1);
            check("a_done_busy", int'(a_busy), 0);
            fin[0] = 1'b0;
        end
        if (b_done) begin
            done_seen[1]++;
            check("b_done_timing", int'(fin[1]), 1);
            check("b_done_with_we", int'(b_wgt_we), 1);
            check("b_done_busy", int'(b_busy), 0);
            fin[1] = 1'b0;
        end
    end

    initial begin
        // reset held with a toggling strobe
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sync_strobe = ~sync_strobe;
            sync_p = 1'b1;
            sync_w = 1'b1;
            check("rst_a_ctl", int'({a_pix_we, a_wgt_we, a_busy, a_done}), 0);
            check("rst_a_data", int'({a_pix_addr, a_pix_wdata, a_wgt_addr, a_wgt_wdata}), 0);
            check("rst_b_ctl", int'({b_pix_we, b_wgt_we, b_busy, b_done}), 0);
        end
        @(negedge clk);
        sync_strobe = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1, 1);
        check("idle_a_busy", int'(a_busy), 0);
        end_phase("idle");

        // 20/20 load: pixels all ones, weights alternating from 1
        do_start(1'b1, 1'b0);
        check("t1_busy", int'(a_busy), 1);
        for (int i = 0; i < 20; i++) strobe(1'b1, (i % 2) == 0, 1);
        end_phase("t1");

        // 8/24 load on the second instance with random data
        do_start(1'b0, 1'b1);
        check("t2_busy", int'(b_busy), 1);
        for (int i = 0; i < 24; i++) strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        end_phase("t2");

        // strobe held high five cycles counts once
        do_start(1'b1, 1'b0);
        strobe(1'b0, 1'b1, 5);
        for (int i = 0; i < 19; i++) strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        end_phase("t3");

        // start coincident with an edge, plus a second start mid-load
        @(negedge clk);
        start_a = 1'b1;
        sync_strobe = 1'b1;
        sync_p = 1'b1;
        sync_w = 1'b1;
        arm(0);
        @(negedge clk);
        start_a = 1'b0;
        sync_strobe = 1'b0;
        for (int i = 0; i < 10; i++) strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        do_start(1'b1, 1'b0);
        check("t4_busy", int'(a_busy), 1);
        for (int i = 0; i < 10; i++) strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        end_phase("t4");

        // reset mid-load aborts, then a fresh load restarts at address 0
        do_start(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        @(negedge clk);
        reset_n = 1'b0;
        armed[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("t5_abort_busy", int'(a_busy), 0);
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b1, 1);
        do_start(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        end_phase("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
